// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - write-back arbiter bus: ALU/LSU results in, register write and hazard lookup out
interface wb_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_WIDTH = 32
);
  logic                  alu_valid_i;
  logic                  alu_ready_o;
  logic [ADDR_WIDTH-1:0] alu_addr_i;
  logic [WORD_WIDTH-1:0] alu_data_i;
  logic                  lsu_valid_i;
  logic [ADDR_WIDTH-1:0] lsu_addr_i;
  logic [WORD_WIDTH-1:0] lsu_data_i;
  logic                  wen_o;
  logic [ADDR_WIDTH-1:0] addr_wd_o;
  logic [WORD_WIDTH-1:0] wd_o;
  logic [ADDR_WIDTH-1:0] chk_addr_i;
  logic                  chk_hit_o;

  // Arbiter side
  modport slave (
    input  alu_valid_i, alu_addr_i, alu_data_i,
    input  lsu_valid_i, lsu_addr_i, lsu_data_i,
    input  chk_addr_i,
    output alu_ready_o, wen_o, addr_wd_o, wd_o, chk_hit_o
  );

  // Pipeline side (ALU, LSU, register bank, decode)
  modport master (
    output alu_valid_i, alu_addr_i, alu_data_i,
    output lsu_valid_i, lsu_addr_i, lsu_data_i,
    output chk_addr_i,
    input  alu_ready_o, wen_o, addr_wd_o, wd_o, chk_hit_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU and LSU results onto the single register-bank write port
module wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int WORD_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [WORD_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  logic full;
  logic empty;
  logic bypass;
  logic push;
  logic pop;

  logic                  sel_valid;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [WORD_WIDTH-1:0] sel_data;

  logic [PTR_W-1:0]      slot_off [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] slot_hit;
  logic                  alu_hit;
  logic                  lsu_hit;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign empty = (count == '0);

  // Ready depends on registered occupancy only, so a popping full FIFO still stalls the ALU.
  assign bus.alu_ready_o = !full;

  // The ALU goes straight to the output register only when nothing older is queued and the LSU is idle.
  assign bypass = empty && bus.alu_valid_i && !bus.lsu_valid_i;
  assign push   = bus.alu_valid_i && !full && !bypass;
  assign pop    = !empty && !bus.lsu_valid_i;

  // Pick the write source: LSU first, then the oldest queued ALU result, then the ALU bypass.
  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = fifo_addr[rd_ptr];
    sel_data  = fifo_data[rd_ptr];
    if (bus.lsu_valid_i) begin
      sel_valid = 1'b1;
      sel_addr  = bus.lsu_addr_i;
      sel_data  = bus.lsu_data_i;
    end else if (!empty) begin
      sel_valid = 1'b1;
    end else if (bus.alu_valid_i) begin
      sel_valid = 1'b1;
      sel_addr  = bus.alu_addr_i;
      sel_data  = bus.alu_data_i;
    end
  end

  // Register the selected write; x0 targets are consumed but never enable the bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wen_o     <= 1'b0;
      bus.addr_wd_o <= '0;
      bus.wd_o      <= '0;
    end else begin
      bus.wen_o <= sel_valid && (sel_addr != '0);
      if (sel_valid) begin
        bus.addr_wd_o <= sel_addr;
        bus.wd_o      <= sel_data;
      end
    end
  end

  // Queue storage; stale slots are masked by occupancy, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.alu_addr_i;
      fifo_data[wr_ptr] <= bus.alu_data_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_slot
    assign slot_off[g] = PTR_W'(g) - rd_ptr;
    assign slot_hit[g] = ({1'b0, slot_off[g]} < count) && (fifo_addr[g] == bus.chk_addr_i);
  end

  assign alu_hit = bus.alu_valid_i && (bus.alu_addr_i == bus.chk_addr_i);
  assign lsu_hit = bus.lsu_valid_i && (bus.lsu_addr_i == bus.chk_addr_i);

  // The output register is left out: the bank forwards its own write-through.
  assign bus.chk_hit_o = (bus.chk_addr_i != '0) && ((|slot_hit) || alu_hit || lsu_hit);
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  wb_arbiter_if #(.ADDR_WIDTH(5), .WORD_WIDTH(32)) bus ();

  wb_arbiter #(.ADDR_WIDTH(5), .WORD_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.alu_valid_i = 1'b0;
    bus.alu_addr_i  = '0;
    bus.alu_data_i  = '0;
    bus.lsu_valid_i = 1'b0;
    bus.lsu_addr_i  = '0;
    bus.lsu_data_i  = '0;
    bus.chk_addr_i  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #3 rst = 1'b1;
    #1;
    total++; if (bus.wen_o !== 1'b0) begin bad++; $display("FAIL reset_wen got=%0h want=0", bus.wen_o); end
    total++; if (bus.addr_wd_o !== 5'd0) begin bad++; $display("FAIL reset_addr got=%0h want=0", bus.addr_wd_o); end
    total++; if (bus.wd_o !== 32'd0) begin bad++; $display("FAIL reset_wd got=%0h want=0", bus.wd_o); end
    total++; if (bus.alu_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h want=1", bus.alu_ready_o); end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_bypass();
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd3; bus.alu_data_i = 32'h11; bus.chk_addr_i = 5'd3;
    #1;
    total++; if (bus.chk_hit_o !== 1'b1) begin bad++; $display("FAIL bypass_chk_alu got=%0h want=1", bus.chk_hit_o); end
    step();
    idle_inputs();
    total++; if (bus.wen_o !== 1'b1) begin bad++; $display("FAIL bypass_wen got=%0h want=1", bus.wen_o); end
    total++; if (bus.addr_wd_o !== 5'd3) begin bad++; $display("FAIL bypass_addr got=%0h want=3", bus.addr_wd_o); end
    total++; if (bus.wd_o !== 32'h11) begin bad++; $display("FAIL bypass_wd got=%0h want=11", bus.wd_o); end
    step();
    total++; if (bus.wen_o !== 1'b0) begin bad++; $display("FAIL bypass_idle_wen got=%0h want=0", bus.wen_o); end
    total++; if (bus.addr_wd_o !== 5'd3) begin bad++; $display("FAIL bypass_hold_addr got=%0h want=3", bus.addr_wd_o); end
  endtask

  task automatic test_collision();
    bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 5'd5; bus.lsu_data_i = 32'hAA;
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd6; bus.alu_data_i = 32'hBB;
    bus.chk_addr_i = 5'd5;
    #1;
    total++; if (bus.chk_hit_o !== 1'b1) begin bad++; $display("FAIL coll_chk_lsu got=%0h want=1", bus.chk_hit_o); end
    bus.chk_addr_i = 5'd9;
    #1;
    total++; if (bus.chk_hit_o !== 1'b0) begin bad++; $display("FAIL coll_chk_miss got=%0h want=0", bus.chk_hit_o); end
    step();
    idle_inputs();
    bus.chk_addr_i = 5'd6;
    #1;
    total++; if (bus.chk_hit_o !== 1'b1) begin bad++; $display("FAIL coll_chk_fifo got=%0h want=1", bus.chk_hit_o); end
    total++; if ({bus.wen_o, bus.addr_wd_o, bus.wd_o} !== {1'b1, 5'd5, 32'hAA})
      begin bad++; $display("FAIL coll_first got=%0h/%0h/%0h want=1/5/aa", bus.wen_o, bus.addr_wd_o, bus.wd_o); end
    step();
    total++; if ({bus.wen_o, bus.addr_wd_o, bus.wd_o} !== {1'b1, 5'd6, 32'hBB})
      begin bad++; $display("FAIL coll_second got=%0h/%0h/%0h want=1/6/bb", bus.wen_o, bus.addr_wd_o, bus.wd_o); end
    total++; if (bus.chk_hit_o !== 1'b0) begin bad++; $display("FAIL coll_chk_drained got=%0h want=0", bus.chk_hit_o); end
    step();
    total++; if (bus.wen_o !== 1'b0) begin bad++; $display("FAIL coll_idle got=%0h want=0", bus.wen_o); end
  endtask

  task automatic test_backpressure();
    logic [4:0]  alu_a [3]  = '{5'd7, 5'd8, 5'd9};
    logic [31:0] alu_d [3]  = '{32'd1, 32'd2, 32'd3};
    logic        lsu_v [8]  = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic        exp_r [8]  = '{1, 1, 0, 0, 0, 1, 1, 1};
    logic        exp_w [8]  = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic [4:0]  exp_a [8]  = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd7, 5'd8, 5'd9, 5'd9};
    logic [31:0] exp_d [8]  = '{32'h100, 32'h101, 32'h102, 32'h103, 32'd1, 32'd2, 32'd3, 32'd3};
    int idx = 0;
    logic acc;
    for (int c = 0; c < 8; c++) begin
      bus.lsu_valid_i = lsu_v[c];
      bus.lsu_addr_i  = 5'(20 + c);
      bus.lsu_data_i  = 32'(256 + c);
      bus.alu_valid_i = (idx < 3);
      bus.alu_addr_i  = (idx < 3) ? alu_a[idx] : 5'd0;
      bus.alu_data_i  = (idx < 3) ? alu_d[idx] : 32'd0;
      #1;
      total++; if (bus.alu_ready_o !== exp_r[c])
        begin bad++; $display("FAIL bp_ready[%0d] got=%0h want=%0h", c, bus.alu_ready_o, exp_r[c]); end
      acc = bus.alu_valid_i && bus.alu_ready_o;
      step();
      if (acc) idx++;
      total++; if ({bus.wen_o, bus.addr_wd_o, bus.wd_o} !== {exp_w[c], exp_a[c], exp_d[c]})
        begin bad++; $display("FAIL bp_write[%0d] got=%0h/%0h/%0h want=%0h/%0h/%0h", c,
          bus.wen_o, bus.addr_wd_o, bus.wd_o, exp_w[c], exp_a[c], exp_d[c]); end
    end
    idle_inputs();
  endtask

  task automatic test_x0_drop();
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd0; bus.alu_data_i = 32'hFFFF; bus.chk_addr_i = 5'd0;
    #1;
    total++; if (bus.chk_hit_o !== 1'b0) begin bad++; $display("FAIL x0_chk got=%0h want=0", bus.chk_hit_o); end
    step();
    idle_inputs();
    total++; if (bus.wen_o !== 1'b0) begin bad++; $display("FAIL x0_bypass_wen got=%0h want=0", bus.wen_o); end
    bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 5'd4; bus.lsu_data_i = 32'h44;
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd0; bus.alu_data_i = 32'hFFFF;
    step();
    idle_inputs();
    #1;
    total++; if (bus.chk_hit_o !== 1'b0) begin bad++; $display("FAIL x0_chk_fifo got=%0h want=0", bus.chk_hit_o); end
    total++; if ({bus.wen_o, bus.addr_wd_o} !== {1'b1, 5'd4})
      begin bad++; $display("FAIL x0_lsu got=%0h/%0h want=1/4", bus.wen_o, bus.addr_wd_o); end
    step();
    total++; if (bus.wen_o !== 1'b0) begin bad++; $display("FAIL x0_fifo_wen got=%0h want=0", bus.wen_o); end
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd10; bus.alu_data_i = 32'h5;
    step();
    idle_inputs();
    total++; if ({bus.wen_o, bus.addr_wd_o, bus.wd_o} !== {1'b1, 5'd10, 32'h5})
      begin bad++; $display("FAIL x0_after got=%0h/%0h/%0h want=1/a/5", bus.wen_o, bus.addr_wd_o, bus.wd_o); end
    step();
  endtask

  task automatic test_hazard_reset();
    bus.lsu_valid_i = 1'b1; bus.lsu_addr_i = 5'd13; bus.lsu_data_i = 32'hD;
    bus.alu_valid_i = 1'b1; bus.alu_addr_i = 5'd12; bus.alu_data_i = 32'hC;
    step();
    bus.alu_valid_i = 1'b0;
    bus.lsu_addr_i = 5'd14; bus.lsu_data_i = 32'hE;
    bus.chk_addr_i = 5'd12;
    #1;
    total++; if (bus.chk_hit_o !== 1'b1) begin bad++; $display("FAIL hz_hit got=%0h want=1", bus.chk_hit_o); end
    #2;
    rst = 1'b1;
    bus.lsu_valid_i = 1'b0;
    #1;
    total++; if (bus.chk_hit_o !== 1'b0) begin bad++; $display("FAIL hz_rst_chk got=%0h want=0", bus.chk_hit_o); end
    total++; if (bus.wen_o !== 1'b0) begin bad++; $display("FAIL hz_rst_wen got=%0h want=0", bus.wen_o); end
    total++; if (bus.alu_ready_o !== 1'b1) begin bad++; $display("FAIL hz_rst_ready got=%0h want=1", bus.alu_ready_o); end
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if ({bus.wen_o, bus.addr_wd_o} !== {1'b0, 5'd0})
        begin bad++; $display("FAIL hz_no_write[%0d] got=%0h/%0h want=0/0", c, bus.wen_o, bus.addr_wd_o); end
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_backpressure();
    test_x0_drop();
    test_hazard_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter that drives the single write port of the integer register bank. It merges single-cycle ALU results and variable-latency LSU load results into one registered write (`wen_o`, `addr_wd_o`, `wd_o`). LSU results always win the port. ALU results that lose arbitration wait in a small FIFO. A combinational pending-write lookup feeds the decode stage's hazard logic.

## Interface
- `ADDR_WIDTH`, default 5: register address width.
- `WORD_WIDTH`, default 32: data width.
- `FIFO_DEPTH`, default 2: number of ALU result buffer entries; power of two, ≥2.

- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset. One clock; reset is asynchronous and active-high.
- `alu_valid_i`  in  1: ALU result available.
- `alu_ready_o`  out  1: ALU result accepted this cycle when high together with `alu_valid_i`.
- `alu_addr_i`  in  ADDR_WIDTH: ALU destination register.
- `alu_data_i`  in  WORD_WIDTH: ALU result.
- `lsu_valid_i`  in  1: load data valid. There is no ready signal; the result is always accepted in that cycle.
- `lsu_addr_i`  in  ADDR_WIDTH: load destination register.
- `lsu_data_i`  in  WORD_WIDTH: load data.
- `wen_o`  out  1: register bank write enable (registered).
- `addr_wd_o`  out  ADDR_WIDTH: write address (registered).
- `wd_o`  out  WORD_WIDTH: write data (registered).
- `chk_addr_i`  in  ADDR_WIDTH: address queried by decode.
- `chk_hit_o`  out  1: `chk_addr_i` has a write still pending in this block.

## Operation
- **Write selection**, evaluated each cycle in priority order:
  1. `lsu_valid_i`.
  2. FIFO head, if the FIFO is not empty.
  3. ALU bypass, if the FIFO is empty and `alu_valid_i` is high.
  4. Otherwise no write.
- **Output register:** the selected source is loaded into the `wen_o`/`addr_wd_o`/`wd_o` register.
  - With no write, `wen_o` is 0 and the address/data outputs hold their previous values.
- **x0 writes:** a selected entry with address 0 is consumed normally, but `wen_o` is driven 0 for it.
- **FIFO push:** happens when `alu_valid_i && alu_ready_o` and the ALU is not taking the bypass path.
  - This covers an LSU/ALU collision with an empty FIFO: the ALU result is pushed.
- **FIFO pop:** happens when the FIFO is non-empty and LSU is not valid.
- **Simultaneous push and pop:** allowed; the occupancy count is unchanged.
- **`alu_ready_o`:** equals `!full` and is computed from registered state only. A full FIFO that is popping this cycle still drives ready low (no comb path from `lsu_valid_i`).
- **Ordering:**
  - ALU results retire in acceptance order.
  - LSU vs. ALU ordering to the same register is not enforced here; issue guarantees no WAW between them.
- **`chk_hit_o`:** 1 if `chk_addr_i != 0` and it matches any of the following:
  - any valid FIFO entry;
  - the current ALU input while `alu_valid_i` is high;
  - the current LSU input while `lsu_valid_i` is high.
  - The output register is excluded: the bank write-through covers it.
- **Occupancy:** tracked by read/write pointers plus a count of width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset** (asynchronous, takes effect immediately):
  - `wen_o`=0, `addr_wd_o`=0, `wd_o`=0.
  - FIFO empty with pointers and count 0, so `alu_ready_o`=1 and `chk_hit_o` is driven by inputs only.
- **Reset mid-operation:** all queued ALU results are discarded and no partial write is emitted.
- **Latency:**
  - LSU: `wen_o` is asserted in the cycle after `lsu_valid_i`.
  - ALU bypass: the same 1-cycle latency.
  - ALU queued: 1 cycle after it reaches the FIFO head and LSU is idle.
- **Throughput:** one register write per cycle.
- **Saturation:** continuous LSU traffic starves the FIFO. The ALU stalls via `alu_ready_o`=0 once FIFO_DEPTH entries are held.
- **Full:** `alu_ready_o`=0; ALU inputs are ignored; nothing is overwritten.
- **Empty:** no pop; the bypass path is used.

## Test plan
- **Reset values:** assert `rst` asynchronously between edges → outputs are 0 immediately and `alu_ready_o`=1.
- **ALU bypass:** ALU valid, addr 3, data 0x11, FIFO empty, LSU idle → next cycle `wen_o`=1, `addr_wd_o`=3, `wd_o`=0x11.
- **Collision:** same cycle LSU (5, 0xAA) and ALU (6, 0xBB) → cycle+1 writes 5/0xAA, cycle+2 writes 6/0xBB.
- **Backpressure:** LSU valid for 4 cycles while the ALU offers (7,1),(8,2),(9,3) → ALU ready drops after 2 accepts; after LSU stops, writes 7/1 then 8/2 in order, then 9/3 is accepted and written.
- **x0 drop:** ALU addr 0, data 0xFFFF → entry consumed, `wen_o` stays 0; `chk_hit_o`=0 when querying addr 0.
- **Hazard lookup and mid-reset:** FIFO holds addr 12, `chk_addr_i`=12 → `chk_hit_o`=1; assert `rst` → `chk_hit_o`=0 and no write of 12 ever appears.
